// File: rtl/acc_register_pkg.sv
// rtl/acc_register_pkg.sv - operation and group-state encodings for acc_register
package acc_register_pkg;

   localparam logic [1:0] MODE_HOLD  = 2'b00;
   localparam logic [1:0] MODE_LOAD  = 2'b01;
   localparam logic [1:0] MODE_CLEAR = 2'b10;
   localparam logic [1:0] MODE_ACC   = 2'b11;

   localparam logic [1:0] ST_EMPTY = 2'b00;
   localparam logic [1:0] ST_ACCUM = 2'b01;
   localparam logic [1:0] ST_FULL  = 2'b10;

   function automatic logic is_term(input logic en, input logic [1:0] mode);
      return en && (mode == MODE_LOAD || mode == MODE_ACC);
   endfunction

endpackage

// File: rtl/acc_register_sat_adder.sv
// rtl/acc_register_sat_adder.sv - combinational signed adder with optional clamp
module sat_adder #(
   parameter int WIDTH    = 16,
   parameter int SATURATE = 1
) (
   input  logic signed [WIDTH-1:0] a,
   input  logic signed [WIDTH-1:0] b,
   output logic signed [WIDTH-1:0] sum,
   output logic                    ovf
);

   localparam logic signed [WIDTH-1:0] MAX_VAL = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic signed [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

   logic signed [WIDTH:0] wide;

   // One guard bit: the true sum leaves range exactly when the top two bits differ
   always_comb begin
      wide = {a[WIDTH-1], a} + {b[WIDTH-1], b};
      ovf  = wide[WIDTH] ^ wide[WIDTH-1];
      sum  = wide[WIDTH-1:0];
      if (ovf && SATURATE != 0) begin
         sum = wide[WIDTH] ? MIN_VAL : MAX_VAL;
      end
   end

endmodule

// File: rtl/acc_register.sv
// rtl/acc_register.sv - grouped signed accumulator with sticky overflow and done pulse
module acc_register
   import acc_register_pkg::*;
#(
   parameter int WIDTH    = 16,
   parameter int ACC_LEN  = 4,
   parameter int SATURATE = 1,
   localparam int CW      = $clog2(ACC_LEN + 1)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    en,
   input  logic [1:0]              mode,
   input  logic signed [WIDTH-1:0] d,
   output logic signed [WIDTH-1:0] q,
   output logic                    ovf,
   output logic                    done,
   output logic [CW-1:0]           cnt
);

   localparam logic [CW-1:0] LEN_C = CW'(ACC_LEN);
   localparam logic [CW-1:0] ONE_C = CW'(1);

   logic [1:0]              state;
   logic                    accept;
   logic                    clear;
   logic                    restart;
   logic [CW-1:0]           cnt_nxt;
   logic signed [WIDTH-1:0] add_sum;
   logic                    add_ovf;

   sat_adder #(
      .WIDTH    (WIDTH),
      .SATURATE (SATURATE)
   ) u_add (
      .a   (q),
      .b   (d),
      .sum (add_sum),
      .ovf (add_ovf)
   );

   // An ACC arriving on a full group starts the next group instead of adding
   always_comb begin
      accept  = is_term(en, mode);
      clear   = en && (mode == MODE_CLEAR);
      restart = (mode == MODE_LOAD) || (state == ST_FULL);
      cnt_nxt = restart ? ONE_C : cnt + ONE_C;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q   <= '0;
         ovf <= 1'b0;
      end else if (clear) begin
         q   <= '0;
         ovf <= 1'b0;
      end else if (accept) begin
         if (restart) begin
            q   <= d;
            ovf <= 1'b0;
         end else begin
            q   <= add_sum;
            ovf <= ovf | add_ovf;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_EMPTY;
         cnt   <= '0;
      end else if (clear) begin
         state <= ST_EMPTY;
         cnt   <= '0;
      end else if (accept) begin
         cnt   <= cnt_nxt;
         state <= (cnt_nxt == LEN_C) ? ST_FULL : ST_ACCUM;
      end
   end

   // Pulse lasts one cycle regardless of en in the following cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         done <= 1'b0;
      end else begin
         done <= accept && !clear && (cnt_nxt == LEN_C);
      end
   end

endmodule

// File: doc/acc_register.md
ACC_REGISTER -- requirements
Module: acc_register

Interface
REQ-001 Parameter WIDTH, default 16; data and accumulator width, two's-complement signed, minimum 2.
REQ-002 Parameter ACC_LEN, default 4; number of terms per accumulation group, minimum 1.
REQ-003 Parameter SATURATE, default 1; 1 = clamp on overflow, 0 = wrap modulo 2^WIDTH.
REQ-004 CLK  input  1  the single clock; all state changes on its rising edge.
REQ-005 RST_N  input  1  reset, asynchronous assertion, active-low.
REQ-006 EN  input  1  operation enable; low = hold all state.
REQ-007 MODE  input  2  operation: 00 HOLD, 01 LOAD, 10 CLEAR, 11 ACC.
REQ-008 D  input  WIDTH  signed operand.
REQ-009 Q  output  WIDTH  registered accumulator value.
REQ-010 OVF  output  1  sticky overflow flag for the current group.
REQ-011 DONE  output  1  one-cycle pulse: group of ACC_LEN terms complete, result on Q.
REQ-012 CNT  output  clog2(ACC_LEN+1)  number of terms accepted in the current group.

Function
REQ-013 A term is accepted on a rising edge where EN=1 and MODE is LOAD or ACC.
REQ-014 EN=0 or MODE=HOLD: Q, OVF, CNT and state unchanged; DONE is 0.
REQ-015 CLEAR (EN=1): Q<=0, OVF<=0, CNT<=0, state EMPTY, DONE 0.
REQ-016 LOAD (any state): Q<=D, OVF<=0, CNT<=1; new group starts.
REQ-017 ACC in EMPTY or ACCUM: Q<=Q+D at WIDTH+1 bits, then saturated or wrapped per SATURATE; CNT<=CNT+1.
REQ-018 ACC in FULL: group restarts; Q<=D, OVF<=0, CNT<=1 (auto-restart, no add to the old result).
REQ-019 Overflow = operands of equal sign and a true sum outside [-2^(WIDTH-1), 2^(WIDTH-1)-1]; OVF set and held until LOAD, CLEAR, restart or reset.
REQ-020 Saturation clamps to +2^(WIDTH-1)-1 for positive overflow and -2^(WIDTH-1) for negative overflow.
REQ-021 State machine EMPTY (CNT=0), ACCUM (0<CNT<ACC_LEN), FULL (CNT=ACC_LEN); transitions only on accepted terms, CLEAR or reset.
REQ-022 On the edge accepting the ACC_LEN-th term: state<=FULL, DONE=1 for exactly the following cycle, independent of EN in that cycle.
REQ-023 With ACC_LEN=1 every accepted term produces a DONE pulse, and state remains FULL.
REQ-024 FULL with HOLD/EN=0: Q, CNT and OVF stay valid; DONE does not repeat.
REQ-025 Latency: Q, CNT, OVF and DONE all reflect an operation one cycle after the accepting edge; no combinational path from inputs to outputs.

Reset
REQ-026 RST_N low asynchronously forces Q=0, OVF=0, DONE=0, CNT=0, state EMPTY.
REQ-027 Reset mid-group discards the partial sum; the first accepted term after release starts a new group.
REQ-028 Deassertion is synchronised to CLK outside this block; the block treats RST_N as clean.

Structure
REQ-029 Shared package holds the MODE encodings (HOLD/LOAD/CLEAR/ACC) and the state encodings (EMPTY/ACCUM/FULL).
REQ-030 One sub-module, sat_adder: WIDTH-parametrised signed adder with SATURATE parameter, outputs sum and overflow, purely combinational.
REQ-031 All storage in acc_register; one always block per register group; no latches.

Verification (WIDTH=8, ACC_LEN=4, SATURATE=1 unless stated)
REQ-032 CLEAR, then ACC 10,20,30,40 on consecutive cycles -> Q=100, CNT=4, DONE high for one cycle after the 4th edge, OVF=0.
REQ-033 LOAD 100, ACC 50 -> Q=127, OVF=1; a further ACC -20 -> Q=107, OVF still 1.
REQ-034 SATURATE=0: LOAD 100, ACC 50 -> Q=-106, OVF=1; LOAD -100, ACC -50 -> Q=106, OVF=1; SATURATE=1 with the same negative operands -> Q=-128.
REQ-035 After DONE (Q=100), hold 3 cycles with EN=0 -> Q=100, no second DONE; then ACC 5 -> Q=5, CNT=1, OVF=0.
REQ-036 ACC 1,2 then RST_N low mid-cycle -> all outputs 0 immediately; after release, ACC 7 -> Q=7, CNT=1.
